// File: rtl/des_pkg.sv
// Shared types and constants for the DES block loader: block/key types, loader
// state encoding and a DES key parity helper.
package des_pkg;

    typedef logic [1:64] des_blk_t;
    typedef logic [1:64] des_key_t;

    localparam int DES_BLK_BYTES = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } des_ld_state_t;

    // DES keys carry odd parity per byte; returns 1 if any byte has even parity.
    function automatic logic key_parity_bad(input des_key_t k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < DES_BLK_BYTES; b++) begin
            if (^k[(b*8)+1 +: 8] == 1'b0) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/des_block_loader_if.sv
// Byte-stream valid/ready interface feeding the DES block loader.
interface des_block_loader_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_is_key;

    modport master (
        output in_valid,
        output in_data,
        output in_is_key,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_is_key,
        output in_ready
    );

endinterface

// File: rtl/des_block_loader_packer.sv
// Byte packer: shifts stream bytes into a 64-bit shadow, counts 8 bytes per
// block, latches the block type on byte 0 and flags mid-block type changes.
module des_byte_packer
    import des_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_xfer,
    input  logic [7:0] i_data,
    input  logic       i_is_key,
    output logic       o_blk_done,
    output logic       o_blk_is_key,
    output des_blk_t   o_blk_data,
    output logic       o_mismatch
);

    des_blk_t   r_shadow;
    logic [2:0] r_cnt;
    logic       r_is_key;
    logic       w_mismatch;

    assign w_mismatch   = i_xfer && (r_cnt != 3'd0) && (i_is_key != r_is_key);
    assign o_mismatch   = w_mismatch;
    // The completing byte is folded in combinationally so the commit happens on its own edge.
    assign o_blk_done   = i_xfer && (r_cnt == 3'd7) && !w_mismatch;
    assign o_blk_is_key = r_is_key;
    assign o_blk_data   = {r_shadow[9:64], i_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_cnt    <= 3'd0;
            r_is_key <= 1'b0;
        end else if (w_mismatch) begin
            r_shadow <= '0;
            r_cnt    <= 3'd0;
        end else if (i_xfer) begin
            r_shadow <= {r_shadow[9:64], i_data};
            r_cnt    <= r_cnt + 3'd1;
            if (r_cnt == 3'd0) begin
                r_is_key <= i_is_key;
            end
        end
    end

endmodule

// File: rtl/des_block_loader.sv
// DES block loader top: commits packed key/message blocks to the DES core and
// holds each message for HOLD_CYCLES. Optional key parity check: PARITY_CHECK_EN.
module des_block_loader
    import des_pkg::*;
#(
    parameter int HOLD_CYCLES = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    des_block_loader_if.slave     s,
    output des_key_t              key,
    output des_blk_t              msg,
    output logic                  blk_valid,
    output logic                  key_loaded,
    output logic                  busy,
    output logic                  err_seq,
    output logic                  err_nokey
`ifdef PARITY_CHECK_EN
    ,
    output logic                  key_err
`endif
);

    localparam int BYTES_PER_BLK = DES_BLK_BYTES;

    des_ld_state_t r_state;
    logic [7:0]    r_hold_cnt;
    des_key_t      r_key;
    des_blk_t      r_msg;
    logic          r_blk_valid;
    logic          r_key_loaded;
    logic          r_busy;
    logic          r_err_seq;
    logic          r_err_nokey;
`ifdef PARITY_CHECK_EN
    logic          r_key_err;
`endif

    logic          w_in_ready;
    logic          w_xfer;
    logic          w_blk_done;
    logic          w_blk_is_key;
    des_blk_t      w_blk_data;
    logic          w_mismatch;
    logic          w_key_ok;

    assign w_in_ready = (r_state == COLLECT) && !rst;
    assign w_xfer     = s.in_valid && w_in_ready;

`ifdef PARITY_CHECK_EN
    assign w_key_ok = r_key_loaded && !r_key_err;
`else
    assign w_key_ok = r_key_loaded;
`endif

    des_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_xfer       (w_xfer),
        .i_data       (s.in_data),
        .i_is_key     (s.in_is_key),
        .o_blk_done   (w_blk_done),
        .o_blk_is_key (w_blk_is_key),
        .o_blk_data   (w_blk_data),
        .o_mismatch   (w_mismatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= COLLECT;
            r_hold_cnt   <= 8'd0;
            r_key        <= '0;
            r_msg        <= '0;
            r_blk_valid  <= 1'b0;
            r_key_loaded <= 1'b0;
            r_busy       <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_nokey  <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_key_err    <= 1'b0;
`endif
        end else begin
            r_blk_valid <= 1'b0;
            r_err_nokey <= 1'b0;
            r_err_seq   <= w_mismatch;
            case (r_state)
                COLLECT: begin
                    if (w_blk_done) begin
                        if (w_blk_is_key) begin
                            r_key        <= w_blk_data;
                            r_key_loaded <= 1'b1;
`ifdef PARITY_CHECK_EN
                            r_key_err    <= key_parity_bad(w_blk_data);
`endif
                        end else if (w_key_ok) begin
                            r_msg       <= w_blk_data;
                            r_blk_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_hold_cnt  <= 8'(HOLD_CYCLES);
                            r_state     <= HOLD;
                        end else begin
                            r_err_nokey <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Counter value equals remaining busy cycles, including the current one.
                    if (r_hold_cnt == 8'd1) begin
                        r_busy  <= 1'b0;
                        r_state <= COLLECT;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign s.in_ready  = w_in_ready;
    assign key         = r_key;
    assign msg         = r_msg;
    assign blk_valid   = r_blk_valid;
    assign key_loaded  = r_key_loaded;
    assign busy        = r_busy;
    assign err_seq     = r_err_seq;
    assign err_nokey   = r_err_nokey;
`ifdef PARITY_CHECK_EN
    assign key_err     = r_key_err;
`endif

endmodule

// File: tb/tb_des_block_loader.sv
// Directed bench for des_block_loader: key/message load, hold timing, error
// pulses, reset during hold and (when enabled) key parity checking.
module tb_des_block_loader;
    import des_pkg::*;

    logic     clk;
    logic     rst;
    des_key_t key;
    des_blk_t msg;
    logic     blk_valid;
    logic     key_loaded;
    logic     busy;
    logic     err_seq;
    logic     err_nokey;
`ifdef PARITY_CHECK_EN
    logic     key_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    des_block_loader_if bus ();

    des_block_loader #(.HOLD_CYCLES(17)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus.slave),
        .key        (key),
        .msg        (msg),
        .blk_valid  (blk_valid),
        .key_loaded (key_loaded),
        .busy       (busy),
        .err_seq    (err_seq),
`ifdef PARITY_CHECK_EN
        .key_err    (key_err),
`endif
        .err_nokey  (err_nokey)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_block(input logic [63:0] v, input logic k);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_is_key = k;
            bus.in_data   = v[63-8*i -: 8];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic count_hold(output int n, output logic ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (busy === 1'b1 && n < 300) begin
            if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int   n_hold;
        logic rdy_in_hold;
        logic [7:0] seq_bytes [5];

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_is_key = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_key", key, 64'd0);
        chk("rst_msg", msg, 64'd0);
        chk("rst_flags", {59'd0, blk_valid, key_loaded, busy, err_seq, err_nokey}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Key load
        send_block(64'h133457799BBCDFF1, 1'b1);
        chk("key_value", key, 64'h133457799BBCDFF1);
        chk("key_loaded", 64'(key_loaded), 64'd1);
        chk("key_no_blk_valid", 64'(blk_valid), 64'd0);
        chk("key_not_busy", 64'(busy), 64'd0);

        // Message load and hold timing
        send_block(64'h0123456789ABCDEF, 1'b0);
        chk("msg_value", msg, 64'h0123456789ABCDEF);
        chk("msg_blk_valid", 64'(blk_valid), 64'd1);
        chk("msg_no_err", {62'd0, err_seq, err_nokey}, 64'd0);
        @(negedge clk);
        #1;
        chk("blk_valid_one_cycle", 64'(blk_valid), 64'd0);
        count_hold(n_hold, rdy_in_hold);
        chk("hold_cycles", 64'(n_hold + 1), 64'd17);
        chk("ready_low_in_hold", 64'(rdy_in_hold), 64'd0);
        chk("ready_after_hold", 64'(bus.in_ready), 64'd1);
        chk("msg_held", msg, 64'h0123456789ABCDEF);
        chk("key_held", key, 64'h133457799BBCDFF1);

        // Sequence error: 4 key bytes, then a message byte
        seq_bytes[0] = 8'hA1; seq_bytes[1] = 8'hB2; seq_bytes[2] = 8'hC3;
        seq_bytes[3] = 8'hD4; seq_bytes[4] = 8'hE5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_is_key = (i < 4);
            bus.in_data   = seq_bytes[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("err_seq_pulse", 64'(err_seq), 64'd1);
        chk("err_seq_key_kept", key, 64'h133457799BBCDFF1);
        chk("err_seq_no_nokey", 64'(err_nokey), 64'd0);
        @(negedge clk);
        #1;
        chk("err_seq_clears", 64'(err_seq), 64'd0);
        send_block(64'h0E329232EA6D0D73, 1'b1);
        chk("key_after_seq_err", key, 64'h0E329232EA6D0D73);
        chk("no_err_after_good_key", {62'd0, err_seq, err_nokey}, 64'd0);

        // No key loaded
        do_reset();
        send_block(64'h0123456789ABCDEF, 1'b0);
        chk("nokey_pulse", 64'(err_nokey), 64'd1);
        chk("nokey_msg_zero", msg, 64'd0);
        chk("nokey_no_blk_valid", 64'(blk_valid), 64'd0);
        chk("nokey_not_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        chk("nokey_clears", {62'd0, err_nokey, blk_valid}, 64'd0);

        // Reset during hold
        send_block(64'h133457799BBCDFF1, 1'b1);
        send_block(64'hFEDCBA9876543210, 1'b0);
        chk("hold2_blk_valid", 64'(blk_valid), 64'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("hold2_busy_c5", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midhold_rst_key", key, 64'd0);
        chk("midhold_rst_msg", msg, 64'd0);
        chk("midhold_rst_flags", {59'd0, blk_valid, key_loaded, busy, err_seq, err_nokey}, 64'd0);
        chk("midhold_rst_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("midhold_post_ready", 64'(bus.in_ready), 64'd1);

`ifdef PARITY_CHECK_EN
        send_block(64'h0000000000000000, 1'b1);
        chk("par_key_err", 64'(key_err), 64'd1);
        send_block(64'h0123456789ABCDEF, 1'b0);
        chk("par_nokey", 64'(err_nokey), 64'd1);
        chk("par_no_blk_valid", 64'(blk_valid), 64'd0);
        send_block(64'h133457799BBCDFF1, 1'b1);
        chk("par_key_err_clear", 64'(key_err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
